// File: rtl/pulse_inc_cnt.sv
// Modulo-MODULO event counter for the watch timekeeping chain.
// carry is combinational so a downstream stage steps on the same edge this one wraps.
module pulse_inc_cnt #(
  parameter int WIDTH  = 8,
  parameter int MODULO = 60
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse,
  output logic [WIDTH-1:0] data,
  output logic             carry
);

  localparam logic [WIDTH-1:0] last_val = WIDTH'(MODULO - 1);

  logic at_last;
  logic below_last;

  assign at_last    = (data == last_val);
  assign below_last = (data < last_val);

  // Anything at or above the last value reloads 0, so a corrupted count self-recovers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (pulse) begin
      if (below_last) data <= data + WIDTH'(1);
      else            data <= '0;
    end
  end

  assign carry = reset & pulse & at_last;

endmodule

// File: tb/tb_pulse_inc_cnt.sv
// Scoreboarded bench: a 60-stage cascaded into a 60-stage, plus a power-of-two modulus instance.
module tb_pulse_inc_cnt;

  logic       clock;
  logic       reset;
  logic       pulse;
  logic [7:0] d1, d2;
  logic [2:0] d3;
  logic       c1, c2, c3;

  pulse_inc_cnt #(.WIDTH(8), .MODULO(60)) u_sec (
    .clock(clock), .reset(reset), .pulse(pulse), .data(d1), .carry(c1));
  pulse_inc_cnt #(.WIDTH(8), .MODULO(60)) u_min (
    .clock(clock), .reset(reset), .pulse(c1), .data(d2), .carry(c2));
  pulse_inc_cnt #(.WIDTH(3), .MODULO(8)) u_pow2 (
    .clock(clock), .reset(reset), .pulse(pulse), .data(d3), .carry(c3));

  typedef struct {
    int d1; int c1; int d2; int c2; int d3; int c3;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   total = 0;   // pulses accepted since the last reset

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge and predict what the
  // monitor will see before the next rising edge.
  task automatic step(input logic p, input logic r);
    exp_t e;
    @(negedge clock);
    #1;
    reset = r;
    pulse = p;
    if (!r) total = 0;
    e.d1 = total % 60;
    e.c1 = (r && p && (total % 60) == 59) ? 1 : 0;
    e.d2 = (total / 60) % 60;
    e.c2 = (r && p && (total % 3600) == 3599) ? 1 : 0;
    e.d3 = total % 8;
    e.c3 = (r && p && (total % 8) == 7) ? 1 : 0;
    q.push_back(e);
    if (r && p) total++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("stage1_data",  int'(d1), e.d1);
        check("stage1_carry", int'(c1), e.c1);
        check("stage2_data",  int'(d2), e.d2);
        check("stage2_carry", int'(c2), e.c2);
        check("pow2_data",    int'(d3), e.d3);
        check("pow2_carry",   int'(c3), e.c3);
      end
    end
  end

  initial begin
    reset = 0;
    pulse = 0;
    // reset held, pulse low then high
    repeat (5) step(0, 0);
    repeat (5) step(1, 0);
    // count through a wrap to 20
    repeat (80) step(1, 1);
    // hold
    repeat (20) step(0, 1);
    // park on 59 with pulse low, then raise it
    repeat (39) step(1, 1);
    step(0, 1);
    step(1, 1);
    step(0, 1);
    // async reset at 37 between edges
    repeat (37) step(1, 1);
    step(1, 0);
    repeat (3) step(1, 1);
    // cascade: 125 pulses from clean reset
    step(0, 0);
    repeat (125) step(1, 1);
    step(0, 1);
    // random run long enough to wrap the second stage
    for (int i = 0; i < 4200; i++) step(($urandom_range(0, 9) != 0), 1'b1);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 1), ($urandom_range(0, 99) != 0));
    step(0, 1);
    repeat (3) @(negedge clock);
    #5;
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
